// File: rtl/flash_pkg.sv
// Shared constants and helpers for the JEDEC byte-program initiator.
package flash_pkg;

    // JEDEC unlock addresses (15-bit offset within the bank) and command bytes
    localparam logic [14:0] UNLK_A1 = 15'h5555;
    localparam logic [14:0] UNLK_A2 = 15'h2AAA;
    localparam logic [7:0]  CMD_AA  = 8'hAA;
    localparam logic [7:0]  CMD_55  = 8'h55;
    localparam logic [7:0]  CMD_PRG = 8'hA0;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_POLL = 2'd2;

    // Bus-cycle phases
    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_SETUP = 3'd1;
    localparam logic [2:0] PH_STRB  = 3'd2;
    localparam logic [2:0] PH_HOLD  = 3'd3;
    localparam logic [2:0] PH_RD    = 3'd4;
    localparam logic [2:0] PH_GAP   = 3'd5;

    // Address of write step k; the bank bits always follow the target so the
    // mapper's 15-bit unlock compare sees the sequence in the right bank.
    function automatic logic [18:0] step_addr(input logic [1:0] k, input logic [18:0] a);
        case (k)
            2'd0:    return {a[18:15], UNLK_A1};
            2'd1:    return {a[18:15], UNLK_A2};
            2'd2:    return {a[18:15], UNLK_A1};
            default: return a;
        endcase
    endfunction

    // Data byte of write step k
    function automatic logic [7:0] step_data(input logic [1:0] k, input logic [7:0] d);
        case (k)
            2'd0:    return CMD_AA;
            2'd1:    return CMD_55;
            2'd2:    return CMD_PRG;
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/flash_bus_cyc.sv
// Single PRG bus cycle engine: write (SETUP/STROBE/HOLD) or read (OE/GAP).
// ack is high in the final cycle so a new start there chains back-to-back.
module flash_bus_cyc
    import flash_pkg::*;
#(
    parameter int WR_CYC = 4,
    parameter int RD_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we_nrd,
    input  logic [18:0] addr,
    input  logic [7:0]  data,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [18:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        bus_oe,
    input  logic [7:0]  bus_din
);

    localparam logic [3:0] WR_LOAD = 4'(WR_CYC - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYC - 1);

    logic [2:0] ph;
    logic [3:0] cnt;

    assign ack = (ph == PH_HOLD) || (ph == PH_GAP);

    // Phase sequencing with registered strobes so the bus never sees glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= PH_IDLE;
            cnt      <= '0;
            bus_addr <= '0;
            bus_dout <= '0;
            bus_we   <= 1'b0;
            bus_oe   <= 1'b0;
            rdata    <= '0;
        end else if (start) begin
            bus_addr <= addr;
            bus_we   <= 1'b0;
            if (we_nrd) begin
                ph       <= PH_SETUP;
                bus_dout <= data;
                bus_oe   <= 1'b0;
                cnt      <= '0;
            end else begin
                ph     <= PH_RD;
                bus_oe <= 1'b1;
                cnt    <= RD_LOAD;
            end
        end else begin
            case (ph)
                PH_SETUP: begin
                    ph     <= PH_STRB;
                    bus_we <= 1'b1;
                    cnt    <= WR_LOAD;
                end
                PH_STRB: begin
                    if (cnt == 4'd0) begin
                        ph     <= PH_HOLD;
                        bus_we <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                PH_RD: begin
                    if (cnt == 4'd0) begin
                        ph     <= PH_GAP;
                        bus_oe <= 1'b0;
                        rdata  <= bus_din;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ph <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_prog_seq.sv
// JEDEC byte-program initiator: unlock, program write, then DQ7 data polling
// with a bounded retry count.
module flash_prog_seq
    import flash_pkg::*;
#(
    parameter int WR_CYC   = 4,
    parameter int RD_CYC   = 3,
    parameter int POLL_MAX = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [18:0] addr,
    input  logic [7:0]  dat,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [18:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        bus_oe,
    input  logic [7:0]  bus_din
);

    localparam int              PC_W      = $clog2(POLL_MAX + 1);
    localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_MAX - 1);

    logic [1:0]      state;
    logic [1:0]      k;
    logic [18:0]     a_q;
    logic [7:0]      d_q;
    logic [PC_W-1:0] poll_cnt;

    logic        start;
    logic        we_nrd;
    logic        ack;
    logic        pass;
    logic        last_poll;
    logic [18:0] cyc_addr;
    logic [7:0]  cyc_data;
    logic [7:0]  rdata;

    assign pass      = (rdata[7] == d_q[7]) && (rdata == d_q);
    assign last_poll = (poll_cnt == POLL_LAST);

    // Launch the next bus cycle in the final cycle of the current one
    always_comb begin
        start    = 1'b0;
        we_nrd   = 1'b1;
        cyc_addr = a_q;
        cyc_data = d_q;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    start    = 1'b1;
                    cyc_addr = step_addr(2'd0, addr);
                    cyc_data = step_data(2'd0, dat);
                end
            end
            ST_CMD: begin
                if (ack) begin
                    start = 1'b1;
                    if (k == 2'd3) begin
                        we_nrd = 1'b0;
                    end else begin
                        cyc_addr = step_addr(k + 2'd1, a_q);
                        cyc_data = step_data(k + 2'd1, d_q);
                    end
                end
            end
            ST_POLL: begin
                if (ack && !pass && !last_poll) begin
                    start  = 1'b1;
                    we_nrd = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Step/poll sequencing and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k        <= 2'd0;
            poll_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_CMD;
                        k        <= 2'd0;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (ack) begin
                        if (k == 2'd3) begin
                            state <= ST_POLL;
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                ST_POLL: begin
                    if (ack) begin
                        poll_cnt <= poll_cnt + PC_W'(1);
                        if (pass) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (last_poll) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the operation operands when a request is accepted
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            a_q <= addr;
            d_q <= dat;
        end
    end

    flash_bus_cyc #(
        .WR_CYC (WR_CYC),
        .RD_CYC (RD_CYC)
    ) u_bus_cyc (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .we_nrd   (we_nrd),
        .addr     (cyc_addr),
        .data     (cyc_data),
        .ack      (ack),
        .rdata    (rdata),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_we   (bus_we),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din)
    );

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq: default-timing instance 0 and a fast
// instance 1 (WR_CYC=2, RD_CYC=1, POLL_MAX=4), each with a flash poll model.
module tb_flash_prog_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req      [2];
    logic [18:0] addr     [2];
    logic [7:0]  dat      [2];
    logic        busy     [2];
    logic        done     [2];
    logic        err      [2];
    logic [18:0] bus_addr [2];
    logic [7:0]  bus_dout [2];
    logic        bus_we   [2];
    logic        bus_oe   [2];
    logic [7:0]  bus_din  [2];

    int checks   = 0;
    int failures = 0;

    logic [26:0] exp0[$], exp1[$], obs0[$], obs1[$];
    logic [1:0]  trace1[$];

    logic       we_p    [2] = '{1'b0, 1'b0};
    logic       oe_p    [2] = '{1'b0, 1'b0};
    int         rd_cnt  [2] = '{0, 0};
    int         rd_base [2] = '{0, 0};
    int         bad_n   [2] = '{0, 0};
    logic [7:0] mval    [2] = '{8'h00, 8'h00};
    logic       both_hi = 1'b0;

    always #5 clk = ~clk;

    flash_prog_seq u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .addr(addr[0]), .dat(dat[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .bus_addr(bus_addr[0]),
        .bus_dout(bus_dout[0]), .bus_we(bus_we[0]), .bus_oe(bus_oe[0]), .bus_din(bus_din[0])
    );

    flash_prog_seq #(.WR_CYC(2), .RD_CYC(1), .POLL_MAX(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .addr(addr[1]), .dat(dat[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .bus_addr(bus_addr[1]),
        .bus_dout(bus_dout[1]), .bus_we(bus_we[1]), .bus_oe(bus_oe[1]), .bus_din(bus_din[1])
    );

    // Flash poll model: the first bad_n reads of an operation return ~mval
    always_comb begin
        for (int i = 0; i < 2; i++)
            bus_din[i] = ((rd_cnt[i] - rd_base[i]) <= bad_n[i]) ? ~mval[i] : mval[i];
    end

    // Bus monitor: collect write strobes, count reads, record strobe trace
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus_we[i] && !we_p[i]) begin
                if (i == 0) obs0.push_back({bus_addr[i], bus_dout[i]});
                else        obs1.push_back({bus_addr[i], bus_dout[i]});
            end
            if (bus_oe[i] && !oe_p[i]) rd_cnt[i] <= rd_cnt[i] + 1;
            if (bus_we[i] && bus_oe[i]) both_hi <= 1'b1;
            we_p[i] <= bus_we[i];
            oe_p[i] <= bus_oe[i];
        end
        if (busy[1]) trace1.push_back({bus_we[1], bus_oe[1]});
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [26:0] exp_w(input logic [18:0] a, input logic [7:0] d, input int k);
        case (k)
            0:       return {a[18:15], 15'h5555, 8'hAA};
            1:       return {a[18:15], 15'h2AAA, 8'h55};
            2:       return {a[18:15], 15'h5555, 8'hA0};
            default: return {a, d};
        endcase
    endfunction

    task automatic push_op(input int i, input logic [18:0] a, input logic [7:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            if (i == 0) exp0.push_back(exp_w(a, d, k));
            else        exp1.push_back(exp_w(a, d, k));
        end
    endtask

    task automatic check_writes(input int i, input string tag);
        logic [26:0] e, o;
        int j = 0;
        while ((i == 0) ? (exp0.size() != 0) : (exp1.size() != 0)) begin
            if (i == 0) e = exp0.pop_front(); else e = exp1.pop_front();
            o = 'x;
            if (i == 0 && obs0.size() != 0) o = obs0.pop_front();
            if (i == 1 && obs1.size() != 0) o = obs1.pop_front();
            chk($sformatf("%s[%0d]", tag, j), 32'(o), 32'(e));
            j++;
        end
        chk({tag, "_extra"}, (i == 0) ? obs0.size() : obs1.size(), 0);
        if (i == 0) obs0.delete(); else obs1.delete();
    endtask

    task automatic run_op(input int i, input logic [18:0] a, input logic [7:0] d, input int bad,
                          output int lat, output logic got_done, output logic got_err,
                          output logic busy1, output logic busy_end, output int reads);
        mval[i] = d; bad_n[i] = bad; rd_base[i] = rd_cnt[i];
        push_op(i, a, d, 4);
        @(negedge clk);
        req[i] = 1'b1; addr[i] = a; dat[i] = d;
        lat = -1; got_done = 1'b0; got_err = 1'b0; busy1 = 1'b0; busy_end = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 1) begin req[i] = 1'b0; busy1 = busy[i]; end
            if (done[i] || err[i]) begin
                lat = n; got_done = done[i]; got_err = err[i]; busy_end = busy[i];
                break;
            end
        end
        reads = rd_cnt[i] - rd_base[i];
    endtask

    initial begin
        int lat, reads, ndone;
        logic gd, ge, b1, be;
        logic [1:0] et[$];

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin req[i] = 1'b0; addr[i] = '0; dat[i] = '0; end
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ctl%0d", i), {busy[i], done[i], err[i], bus_we[i], bus_oe[i]}, 0);
            chk($sformatf("reset_bus%0d", i), {bus_addr[i], bus_dout[i]}, 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Nominal program, default timing
        run_op(0, 19'h4_1234, 8'h5A, 0, lat, gd, ge, b1, be, reads);
        chk("nom_latency", lat, 29);
        chk("nom_done", gd, 1);
        chk("nom_err", ge, 0);
        chk("nom_busy_c1", b1, 1);
        chk("nom_busy_end", be, 0);
        chk("nom_reads", reads, 1);
        check_writes(0, "nom_wr");

        // Strobe timing on the fast instance
        trace1.delete();
        run_op(1, 19'h1_0F0F, 8'h3C, 0, lat, gd, ge, b1, be, reads);
        chk("strb_latency", lat, 19);
        chk("strb_done", gd, 1);
        chk("strb_reads", reads, 1);
        check_writes(1, "strb_wr");
        for (int s = 0; s < 4; s++) begin
            et.push_back(2'b00);
            repeat (2) et.push_back(2'b10);
            et.push_back(2'b00);
        end
        et.push_back(2'b01);
        et.push_back(2'b00);
        chk("trace_len", trace1.size(), et.size());
        for (int j = 0; j < et.size(); j++)
            chk($sformatf("trace[%0d]", j), (j < trace1.size()) ? trace1[j] : 2'bxx, et[j]);

        // Slow completion: 7 failing polls then a match
        run_op(0, 19'h7_7FFE, 8'h5A, 7, lat, gd, ge, b1, be, reads);
        chk("slow_reads", reads, 8);
        chk("slow_latency", lat, 57);
        chk("slow_done", gd, 1);
        chk("slow_err", ge, 0);
        check_writes(0, "slow_wr");

        // Timeout with POLL_MAX=4
        run_op(1, 19'h6_0001, 8'h81, 1000, lat, gd, ge, b1, be, reads);
        chk("tmo_reads", reads, 4);
        chk("tmo_latency", lat, 25);
        chk("tmo_err", ge, 1);
        chk("tmo_done", gd, 0);
        chk("tmo_busy_end", be, 0);
        check_writes(1, "tmo_wr");

        // Second req while busy is ignored
        mval[0] = 8'hC3; bad_n[0] = 0; rd_base[0] = rd_cnt[0];
        push_op(0, 19'h2_0100, 8'hC3, 4);
        @(negedge clk); req[0] = 1'b1; addr[0] = 19'h2_0100; dat[0] = 8'hC3;
        @(negedge clk); req[0] = 1'b0;
        repeat (4) @(negedge clk);
        req[0] = 1'b1; addr[0] = 19'h5_7777; dat[0] = 8'h11;
        @(negedge clk); req[0] = 1'b0;
        ndone = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("busyreq_done_cnt", ndone, 1);
        check_writes(0, "busyreq_wr");

        // Reset in the middle of the k2 strobe
        mval[0] = 8'h96; bad_n[0] = 0; rd_base[0] = rd_cnt[0];
        push_op(0, 19'h3_4567, 8'h96, 3);
        @(negedge clk); req[0] = 1'b1; addr[0] = 19'h3_4567; dat[0] = 8'h96;
        @(negedge clk); req[0] = 1'b0;
        for (int n = 0; n < 200 && obs0.size() < 3; n++) @(negedge clk);
        chk("rst_mid_we", bus_we[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_async", bus_we[0], 0);
        chk("rst_busy_async", busy[0], 0);
        chk("rst_addr_async", bus_addr[0], 0);
        @(negedge clk); rst_n = 1'b1;
        check_writes(0, "rst_abort_wr");
        run_op(0, 19'h3_4567, 8'h96, 0, lat, gd, ge, b1, be, reads);
        chk("rst_restart_latency", lat, 29);
        chk("rst_restart_done", gd, 1);
        check_writes(0, "rst_restart_wr");

        chk("we_oe_overlap", both_hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
